// File: rtl/cereal_sched.sv
// Round-robin scheduler sharing one cereal byte serializer between N_REQ requesters.
// Latches the winner's byte, holds ser_start for a frame, pulses done, then idles for a guard gap.
module cereal_sched #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned FRAME_CYCLES = 5000,
  parameter int unsigned GAP_CYCLES   = 16
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic                 busy,
  output logic                 ser_start,
  output logic [7:0]           ser_data,
  output logic [15:0]          frame_count
);

  localparam int unsigned IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned MAXC = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_RST   = IW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

  state_t            r_state, w_nxt_state;
  logic [CW-1:0]     r_cnt, w_nxt_cnt;
  logic [IW-1:0]     r_last, w_nxt_last;
  logic [N_REQ-1:0]  r_grant, w_nxt_grant;
  logic [N_REQ-1:0]  r_done, w_nxt_done;
  logic              r_busy, w_nxt_busy;
  logic              r_ser_start, w_nxt_ser_start;
  logic [7:0]        r_ser_data, w_nxt_ser_data;
  logic [15:0]       r_frame_count, w_nxt_frame_count;

  logic              w_found;
  logic [IW-1:0]     w_win;
  int unsigned       w_idx;

  // Round-robin search starting just after the previous winner
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_idx   = 0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      w_idx = (32'(r_last) + off) % N_REQ;
      if (!w_found && req[IW'(w_idx)]) begin
        w_found = 1'b1;
        w_win   = IW'(w_idx);
      end
    end
  end

  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_cnt         = r_cnt;
    w_nxt_last        = r_last;
    w_nxt_grant       = r_grant;
    w_nxt_done        = '0;
    w_nxt_ser_start   = r_ser_start;
    w_nxt_ser_data    = r_ser_data;
    w_nxt_frame_count = r_frame_count;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_nxt_grant    = ONE_HOT0 << w_win;
          w_nxt_ser_data = req_data[{w_win, 3'b000} +: 8];
          w_nxt_last     = w_win;
          w_nxt_state    = S_LOAD;
        end
      end
      S_LOAD: begin
        w_nxt_state     = S_SEND;
        w_nxt_ser_start = 1'b1;
        w_nxt_cnt       = '0;
      end
      S_SEND: begin
        if (r_cnt == FRAME_LAST) begin
          w_nxt_state       = S_GAP;
          w_nxt_ser_start   = 1'b0;
          w_nxt_grant       = '0;
          w_nxt_done        = r_grant;
          w_nxt_frame_count = r_frame_count + 16'd1;
          w_nxt_cnt         = '0;
        end else begin
          w_nxt_cnt = r_cnt + CW'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_nxt_state = S_IDLE;
        end else begin
          w_nxt_cnt = r_cnt + CW'(1);
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
    w_nxt_busy = (w_nxt_state != S_IDLE);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_last        <= LAST_RST;
      r_grant       <= '0;
      r_done        <= '0;
      r_busy        <= 1'b0;
      r_ser_start   <= 1'b0;
      r_ser_data    <= '0;
      r_frame_count <= '0;
    end else begin
      r_state       <= w_nxt_state;
      r_cnt         <= w_nxt_cnt;
      r_last        <= w_nxt_last;
      r_grant       <= w_nxt_grant;
      r_done        <= w_nxt_done;
      r_busy        <= w_nxt_busy;
      r_ser_start   <= w_nxt_ser_start;
      r_ser_data    <= w_nxt_ser_data;
      r_frame_count <= w_nxt_frame_count;
    end
  end

  assign grant       = r_grant;
  assign done        = r_done;
  assign busy        = r_busy;
  assign ser_start   = r_ser_start;
  assign ser_data    = r_ser_data;
  assign frame_count = r_frame_count;

endmodule
